sha512_rd_fetch: RTL and testbench

//  Host-memory read engine feeding the SHA-512 core. Sits downstream of the CSR block:

---
 rtl/sha512_rd_fetch.sv | 160 ++++++++++++++++
 tb/tb_sha512_rd_fetch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha512_rd_fetch.sv
// sha512_rd_fetch: host-memory read engine for the SHA-512 core.
// Issues CCI-P c0 line reads for a source buffer, reorders the responses
// through a small slot buffer and hands out 1024-bit blocks (two lines) in order.
module sha512_rd_fetch #(
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [31:0]         num_lines,
  input  logic                rd_almfull,
  output logic                rd_req_valid,
  output logic [ADDR_W-1:0]   rd_req_addr,
  output logic [15:0]         rd_req_mdata,
  input  logic                rd_rsp_valid,
  input  logic [15:0]         rd_rsp_mdata,
  input  logic [511:0]        rd_rsp_data,
  output logic                blk_valid,
  output logic [1023:0]       blk_data,
  output logic                blk_last,
  input  logic                blk_ready,
  output logic                busy,
  output logic                done,
  output logic                err_tag
);

  localparam int unsigned IdxW = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFinish} state_e;

  state_e                     state_q;
  logic [ADDR_W-1:0]          base_q;
  logic [31:0]                num_q;
  logic [31:0]                req_cnt_q;   // lines requested so far
  logic [31:0]                head_q;      // index of first line of the next block
  logic [MAX_OUTSTANDING-1:0] pending_q;   // request issued, response not yet seen
  logic [MAX_OUTSTANDING-1:0] filled_q;    // data held, waiting for block handshake
  logic [511:0]               slot_data_q [MAX_OUTSTANDING];

  logic [IdxW-1:0] req_slot;
  logic [IdxW-1:0] rsp_slot;
  logic [IdxW-1:0] head_slot;
  logic [IdxW-1:0] head_slot_nx;
  logic [31:0]     remaining;
  logic            head_single;
  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_bad;
  logic            blk_load;
  logic            blk_fire;

  assign req_slot     = req_cnt_q[IdxW-1:0];
  assign rsp_slot     = rd_rsp_mdata[IdxW-1:0];
  assign head_slot    = head_q[IdxW-1:0];
  assign head_slot_nx = head_slot + IdxW'(1);
  assign remaining    = num_q - head_q;
  // Odd line count: the final block carries a single line.
  assign head_single  = (remaining == 32'd1);
  assign busy         = (state_q != StIdle);

  // A slot is reusable only once its data has left through a block handshake.
  assign req_fire = (state_q == StFetch) && !rd_almfull && (req_cnt_q < num_q) &&
                    !pending_q[req_slot] && !filled_q[req_slot];

  assign rsp_ok  = rd_rsp_valid && ((rd_rsp_mdata >> IdxW) == 16'd0) && pending_q[rsp_slot];
  assign rsp_bad = rd_rsp_valid && !rsp_ok;

  assign blk_load = ((state_q == StFetch) || (state_q == StDrain)) && !blk_valid &&
                    (head_q < num_q) && filled_q[head_slot] &&
                    (head_single || filled_q[head_slot_nx]);
  assign blk_fire = blk_valid && blk_ready;

  // Control FSM, request issue, slot bookkeeping and registered block output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      num_q        <= '0;
      req_cnt_q    <= '0;
      head_q       <= '0;
      pending_q    <= '0;
      filled_q     <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      blk_valid    <= 1'b0;
      blk_data     <= '0;
      blk_last     <= 1'b0;
      done         <= 1'b0;
      err_tag      <= 1'b0;
    end else begin
      rd_req_valid <= 1'b0;
      done         <= 1'b0;

      if (rsp_ok) begin
        pending_q[rsp_slot] <= 1'b0;
        filled_q[rsp_slot]  <= 1'b1;
      end

      if (req_fire) begin
        rd_req_valid        <= 1'b1;
        rd_req_addr         <= base_q + ADDR_W'(req_cnt_q);
        rd_req_mdata        <= 16'(req_slot);
        pending_q[req_slot] <= 1'b1;
        req_cnt_q           <= req_cnt_q + 32'd1;
      end

      if (blk_load) begin
        blk_valid <= 1'b1;
        blk_data  <= head_single ? {512'd0, slot_data_q[head_slot]}
                                 : {slot_data_q[head_slot_nx], slot_data_q[head_slot]};
        blk_last  <= (remaining <= 32'd2);
      end

      // Fill (rsp_slot) and free (head slots) never target the same slot.
      if (blk_fire) begin
        blk_valid           <= 1'b0;
        blk_last            <= 1'b0;
        filled_q[head_slot] <= 1'b0;
        if (!head_single) filled_q[head_slot_nx] <= 1'b0;
        head_q              <= head_q + 32'd2;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            base_q    <= src_addr;
            num_q     <= num_lines;
            req_cnt_q <= '0;
            head_q    <= '0;
            err_tag   <= 1'b0;
            state_q   <= (num_lines == 32'd0) ? StFinish : StFetch;
          end
        end
        StFetch: begin
          if (req_fire && (req_cnt_q + 32'd1 == num_q)) state_q <= StDrain;
        end
        StDrain: begin
          if (blk_fire && blk_last) state_q <= StFinish;
        end
        StFinish: begin
          state_q <= StIdle;
          done    <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase

      // Placed after the start clear so a bad tag in the start cycle still sticks.
      if (rsp_bad) err_tag <= 1'b1;
    end
  end

  // Reorder storage; contents are don't-care until the filled bit is set.
  always_ff @(posedge clk) begin
    if (rsp_ok) slot_data_q[rsp_slot] <= rd_rsp_data;
  end

endmodule

// File: tb/tb_sha512_rd_fetch.sv
// Directed bench for sha512_rd_fetch: table of fetch jobs plus hand-written
// sequences for reordering, almost-full, backpressure, bad tags and reset.
`timescale 1ns/1ps
module tb_sha512_rd_fetch;

  localparam int unsigned AW = 42;
  localparam int unsigned MO = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [AW-1:0]   src_addr;
  logic [31:0]     num_lines;
  logic            rd_almfull;
  logic            rd_req_valid;
  logic [AW-1:0]   rd_req_addr;
  logic [15:0]     rd_req_mdata;
  logic            rd_rsp_valid;
  logic [15:0]     rd_rsp_mdata;
  logic [511:0]    rd_rsp_data;
  logic            blk_valid;
  logic [1023:0]   blk_data;
  logic            blk_last;
  logic            blk_ready;
  logic            busy;
  logic            done;
  logic            err_tag;

  sha512_rd_fetch #(.ADDR_W(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .src_addr     (src_addr),
    .num_lines    (num_lines),
    .rd_almfull   (rd_almfull),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_mdata (rd_req_mdata),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_mdata (rd_rsp_mdata),
    .rd_rsp_data  (rd_rsp_data),
    .blk_valid    (blk_valid),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .busy         (busy),
    .done         (done),
    .err_tag      (err_tag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected job and observed counters.
  logic [AW-1:0] exp_base = '0;
  int exp_n       = 0;
  int req_count   = 0;
  int blk_count   = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int last_hs_cyc = 0;

  typedef struct packed {
    logic [15:0]   tag;
    logic [AW-1:0] addr;
  } req_t;

  req_t         pend_q[$];
  logic [15:0]  inj_tag_q[$];
  logic [511:0] inj_dat_q[$];
  bit           auto_rsp = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    int            n;
    int            reqs;
    int            blks;
  } vec_t;

  vec_t vec [6];

  function automatic logic [511:0] line_of(input logic [AW-1:0] a);
    return {8{{a[31:0], ~a[31:0]}}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] a, input int n);
    exp_base  = a;
    exp_n     = n;
    req_count = 0;
    blk_count = 0;
    src_addr  = a;
    num_lines = 32'(n);
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < max_cyc) begin
      step(1);
      i++;
    end
    chk("done_seen", 512'(done_cnt != d0), 512'(1));
  endtask

  task automatic wait_reqs(input int n, input int max_cyc);
    int i;
    i = 0;
    while (req_count < n && i < max_cyc) begin
      step(1);
      i++;
    end
    chk("reqs_reached", 512'(req_count >= n), 512'(1));
  endtask

  task automatic inject(input logic [15:0] tag, input logic [511:0] data);
    inj_tag_q.push_back(tag);
    inj_dat_q.push_back(data);
  endtask

  always @(posedge clk) cyc++;

  // Observe requests, block handshakes and done away from the active edge.
  always @(negedge clk) begin : mon
    logic [AW-1:0] ea;
    logic [511:0]  lo_exp;
    logic [511:0]  hi_exp;
    int            k;
    if (reset_n) begin
      if (rd_req_valid) begin
        ea = exp_base + AW'(req_count);
        chk("req_addr", 512'(rd_req_addr), 512'(ea));
        chk("req_tag", 512'(rd_req_mdata), 512'(req_count % MO));
        pend_q.push_back('{tag: rd_req_mdata, addr: rd_req_addr});
        req_count++;
      end
      if (blk_valid && blk_ready) begin
        k      = blk_count;
        lo_exp = line_of(exp_base + AW'(2 * k));
        hi_exp = (2 * k + 1 < exp_n) ? line_of(exp_base + AW'(2 * k + 1)) : '0;
        chk("blk_lo", blk_data[511:0], lo_exp);
        chk("blk_hi", blk_data[1023:512], hi_exp);
        chk("blk_last", 512'(blk_last), 512'(2 * k + 2 >= exp_n));
        blk_count++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Memory model: injected responses first, otherwise in-order auto replies.
  always @(posedge clk) begin : rsp
    req_t r;
    #1;
    rd_rsp_valid = 1'b0;
    if (inj_tag_q.size() > 0) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = inj_tag_q.pop_front();
      rd_rsp_data  = inj_dat_q.pop_front();
    end else if (auto_rsp && pend_q.size() > 0) begin
      r            = pend_q.pop_front();
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = r.tag;
      rd_rsp_data  = line_of(r.addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int snap;
    vec[0] = '{42'h100, 4, 4, 2};
    vec[1] = '{42'h3FF_FFFF_FFFE, 4, 4, 2};  // address wraps past 2^42
    vec[2] = '{42'h200, 3, 3, 2};
    vec[3] = '{42'h1000, 1, 1, 1};
    vec[4] = '{42'h40, 17, 17, 9};
    vec[5] = '{42'h0, 0, 0, 0};

    reset_n      = 1'b1;
    start        = 1'b0;
    src_addr     = '0;
    num_lines    = '0;
    rd_almfull   = 1'b0;
    blk_ready    = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_mdata = '0;
    rd_rsp_data  = '0;
    #2 reset_n = 1'b0;
    step(3);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_req_valid", 512'(rd_req_valid), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_err_tag", 512'(err_tag), 512'(0));
    reset_n = 1'b1;
    step(2);

    // Table of whole jobs with in-order responses and a ready consumer.
    for (int i = 0; i < 6; i++) begin
      pend_q.delete();
      auto_rsp  = 1'b1;
      blk_ready = 1'b1;
      do_start(vec[i].addr, vec[i].n);
      wait_done(300);
      step(1);
      chk("req_total", 512'(req_count), 512'(vec[i].reqs));
      chk("blk_total", 512'(blk_count), 512'(vec[i].blks));
      chk("busy_end", 512'(busy), 512'(0));
      chk("err_clean", 512'(err_tag), 512'(0));
      // Handshake edge and done edge are one clock apart; negedge samples sit 2 apart.
      if (vec[i].n > 0) chk("done_latency", 512'(done_cyc - last_hs_cyc), 512'(2));
    end

    // Zero-length job: done two cycles after start, busy for one.
    pend_q.delete();
    do_start(42'h800, 0);
    chk("z_busy1", 512'(busy), 512'(1));
    chk("z_done1", 512'(done), 512'(0));
    step(1);
    chk("z_busy2", 512'(busy), 512'(0));
    chk("z_done2", 512'(done), 512'(1));
    step(1);
    chk("z_done3", 512'(done), 512'(0));
    chk("z_reqs", 512'(req_count), 512'(0));

    // Out-of-order responses 3,1,0,2.
    pend_q.delete();
    auto_rsp  = 1'b0;
    blk_ready = 1'b1;
    do_start(42'h500, 4);
    wait_reqs(4, 50);
    inject(16'd3, line_of(42'h503));
    inject(16'd1, line_of(42'h501));
    step(6);
    chk("ooo_no_early_blk", 512'(blk_count), 512'(0));
    chk("ooo_no_valid", 512'(blk_valid), 512'(0));
    inject(16'd0, line_of(42'h500));
    inject(16'd2, line_of(42'h502));
    wait_done(50);
    chk("ooo_blks", 512'(blk_count), 512'(2));
    chk("ooo_err", 512'(err_tag), 512'(0));

    // Almost-full window mid-fetch.
    pend_q.delete();
    auto_rsp = 1'b1;
    do_start(42'h4000, 16);
    step(2);
    rd_almfull = 1'b1;
    step(1);
    snap = req_count;
    step(10);
    chk("almfull_quiet", 512'(req_count), 512'(snap));
    chk("almfull_mid", 512'(snap < 16), 512'(1));
    rd_almfull = 1'b0;
    wait_done(300);
    chk("almfull_reqs", 512'(req_count), 512'(16));
    chk("almfull_blks", 512'(blk_count), 512'(8));

    // Consumer stalled: requests stop at the slot limit; a start meanwhile is dropped.
    pend_q.delete();
    blk_ready = 1'b0;
    do_start(42'h2000, 20);
    step(40);
    chk("bp_reqs", 512'(req_count), 512'(MO));
    chk("bp_valid", 512'(blk_valid), 512'(1));
    chk("bp_blks", 512'(blk_count), 512'(0));
    src_addr  = 42'h9999;
    num_lines = 32'd2;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
    step(2);
    chk("bp_busy", 512'(busy), 512'(1));
    blk_ready = 1'b1;
    wait_done(400);
    chk("bp_reqs_end", 512'(req_count), 512'(20));
    chk("bp_blks_end", 512'(blk_count), 512'(10));

    // Tag with nonzero upper bits is discarded and flagged.
    pend_q.delete();
    auto_rsp = 1'b0;
    do_start(42'h600, 2);
    wait_reqs(2, 50);
    inject(16'h0100, ~line_of(42'h600));
    step(4);
    chk("bogus_err", 512'(err_tag), 512'(1));
    inject(16'd0, line_of(42'h600));
    inject(16'd1, line_of(42'h601));
    wait_done(50);
    chk("bogus_blks", 512'(blk_count), 512'(1));
    chk("bogus_sticky", 512'(err_tag), 512'(1));

    // Reset mid-fetch; a late response afterwards flags err_tag.
    pend_q.delete();
    do_start(42'h700, 16);
    chk("start_clears_err", 512'(err_tag), 512'(0));
    wait_reqs(3, 50);
    reset_n = 1'b0;
    #1;
    chk("mr_req_valid", 512'(rd_req_valid), 512'(0));
    chk("mr_req_addr", 512'(rd_req_addr), 512'(0));
    chk("mr_req_mdata", 512'(rd_req_mdata), 512'(0));
    chk("mr_blk_valid", 512'(blk_valid), 512'(0));
    chk("mr_blk_lo", blk_data[511:0], 512'(0));
    chk("mr_blk_hi", blk_data[1023:512], 512'(0));
    chk("mr_blk_last", 512'(blk_last), 512'(0));
    chk("mr_busy", 512'(busy), 512'(0));
    chk("mr_done", 512'(done), 512'(0));
    step(2);
    reset_n = 1'b1;
    step(2);
    pend_q.delete();
    inject(16'd1, line_of(42'h701));
    step(3);
    chk("late_rsp_err", 512'(err_tag), 512'(1));
    do_start(42'h0, 0);
    chk("late_err_cleared", 512'(err_tag), 512'(0));
    wait_done(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
